// File: rtl/seq_shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier_pkg
// Description : Shared definitions for the sequential shift-add multiplier:
//               FSM state encoding and width helper functions.
// Contents    : state_e       - ST_IDLE / ST_RUN, explicit 1-bit encoding
//               count_width   - bits needed to hold an iteration count 0..N
//               product_width - product / accumulator width (2N)
// Revision    : 1.0 - initial release
// ============================================================================
package seq_shift_add_multiplier_pkg;

  // Two-state controller: waiting for an operand pair, or retiring bits.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // The counter is loaded with N itself, so it must represent N, not N-1.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  // 2N bits hold any N x N product: (2^N-1)^2 < 2^2N.
  function automatic int product_width(input int n);
    return 2 * n;
  endfunction

endpackage : seq_shift_add_multiplier_pkg
`default_nettype wire

// File: rtl/seq_shift_add_multiplier_operand_abs.sv
`default_nettype none
// ============================================================================
// Module      : mul_operand_abs
// Description : N-bit two's-complement magnitude extractor. When signed_i is
//               set and the operand is negative, returns its negation and
//               flags the sign; otherwise passes the operand through.
//               The most negative value -2^(N-1) yields magnitude 2^(N-1),
//               which is representable as an unsigned N-bit quantity.
// Ports       : val_i    in  N  operand
//               signed_i in  1  1 = interpret val_i as two's complement
//               mag_o    out N  unsigned magnitude
//               neg_o    out 1  1 = operand was negative
// Revision    : 1.0 - initial release
// ============================================================================
module mul_operand_abs #(
  parameter int N = 8
) (
  input  logic [N-1:0] val_i,
  input  logic         signed_i,
  output logic [N-1:0] mag_o,
  output logic         neg_o
);

  always_comb begin
    neg_o = signed_i & val_i[N-1];
    mag_o = neg_o ? (~val_i + N'(1)) : val_i;
  end

endmodule : mul_operand_abs
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Sequential shift-add multiplier. Accepts two N-bit operands
//               on an init/ready handshake, retires one multiplier bit per
//               clock and returns a 2N-bit product with a one-cycle
//               finished strobe. The product register holds its value until
//               the next finished strobe.
// Parameters  : N          operand width (>= 2), product is 2N bits
//               EARLY_EXIT 1 = stop once remaining multiplier bits are zero
// Build macro : SEQ_MUL_SIGNED_EN - adds the signed_mode port and signed
//               (two's complement) multiplication via magnitude + sign.
// Ports       : clk         in  1   clock, rising edge
//               rst_n       in  1   asynchronous active-low reset
//               init        in  1   start request, honoured while ready=1
//               input_a     in  N   multiplicand, sampled with init
//               input_b     in  N   multiplier, sampled with init
//               signed_mode in  1   (SEQ_MUL_SIGNED_EN) signed operands
//               ready       out 1   controller idle, init will be accepted
//               finished    out 1   one-cycle result-valid strobe
//               result      out 2N  product
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int N          = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init,
  input  logic [N-1:0]   input_a,
  input  logic [N-1:0]   input_b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic           signed_mode,
`endif
  output logic           ready,
  output logic           finished,
  output logic [2*N-1:0] result
);

  localparam int PW = product_width(N);
  localparam int CW = count_width(N);

  // --------------------------------------------------------------------------
  // Operand conditioning: the datapath below is purely unsigned. In signed
  // builds the magnitudes are multiplied and the sign is applied at the end.
  // --------------------------------------------------------------------------
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         op_neg;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg_a;
  logic neg_b;

  mul_operand_abs #(.N(N)) u_abs_a (
    .val_i    (input_a),
    .signed_i (signed_mode),
    .mag_o    (op_a),
    .neg_o    (neg_a)
  );

  mul_operand_abs #(.N(N)) u_abs_b (
    .val_i    (input_b),
    .signed_i (signed_mode),
    .mag_o    (op_b),
    .neg_o    (neg_b)
  );

  assign op_neg = neg_a ^ neg_b;
`else
  assign op_a   = input_a;
  assign op_b   = input_b;
  assign op_neg = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e          state_q,    state_d;
  logic [PW-1:0]   mcand_q,    mcand_d;
  logic [N-1:0]    mplier_q,   mplier_d;
  logic [PW-1:0]   acc_q,      acc_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [PW-1:0]   result_q,   result_d;
  logic            finished_q, finished_d;
`ifdef SEQ_MUL_SIGNED_EN
  logic            neg_q,      neg_d;
`endif

  // Partial-product sum for the current multiplier bit.
  logic [PW-1:0] acc_sum;
  logic          last_iter;

  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
    // Either the fixed iteration budget is spent, or (optionally) every
    // multiplier bit that would be consumed later is zero, so acc_sum is
    // already the final product.
    last_iter = (count_q == CW'(1)) ||
                (EARLY_EXIT && (mplier_q[N-1:1] == {(N-1){1'b0}}));
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    count_d    = count_q;
    result_d   = result_q;
    finished_d = 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
    neg_d      = neg_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (init) begin
          mcand_d  = {{(PW-N){1'b0}}, op_a};
          mplier_d = op_b;
          acc_d    = {PW{1'b0}};
          count_d  = CW'(N);
          state_d  = ST_RUN;
`ifdef SEQ_MUL_SIGNED_EN
          neg_d    = op_neg;
`endif
        end
      end

      ST_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (last_iter) begin
`ifdef SEQ_MUL_SIGNED_EN
          result_d = neg_q ? ({PW{1'b0}} - acc_sum) : acc_sum;
`else
          result_d = acc_sum;
`endif
          finished_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mcand_q    <= {PW{1'b0}};
      mplier_q   <= {N{1'b0}};
      acc_q      <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      result_q   <= {PW{1'b0}};
      finished_q <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      result_q   <= result_d;
      finished_q <= finished_d;
`ifdef SEQ_MUL_SIGNED_EN
      neg_q      <= neg_d;
`endif
    end
  end

  // op_neg only feeds the sign register in signed builds.
  logic unused_ok;
  assign unused_ok = op_neg;

  assign ready    = (state_q == ST_IDLE);
  assign finished = finished_q;
  assign result   = result_q;

endmodule : seq_shift_add_multiplier
`default_nettype wire
